// File: rtl/synth_pkg.sv
// -----------------------------------------------------------------------------
// synth_pkg
// Shared types and constants for the synthesizer voice datapath.
//   env_state_t   : ADSR envelope state encoding (IDLE..RELEASE)
//   ENV_W_DEFAULT : default envelope level width
//   ENV_MAX       : full-scale envelope level at the default width
//   STATE_W       : width of the envelope state encoding
// -----------------------------------------------------------------------------
package synth_pkg;

    localparam int ENV_W_DEFAULT = 16;
    localparam int STATE_W       = 3;

    localparam logic [ENV_W_DEFAULT-1:0] ENV_MAX = 16'hFFFF;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } env_state_t;

endpackage

// File: rtl/env_vca_mult.sv
// -----------------------------------------------------------------------------
// env_vca_mult
// Registered VCA: signed sample times unsigned envelope level, arithmetic
// shift right by ENV_W (floor division), truncated to SAMPLE_W.
// Ports:
//   i_clk     : clock
//   i_rst_n   : asynchronous active-low reset
//   i_en      : sample strobe; output register loads when high
//   i_sample  : signed input sample (SAMPLE_W)
//   i_env     : unsigned envelope level (ENV_W)
//   o_sample  : registered scaled sample (SAMPLE_W)
//   o_valid   : one-cycle pulse the cycle after i_en
// -----------------------------------------------------------------------------
module env_vca_mult #(
    parameter int ENV_W    = 16,
    parameter int SAMPLE_W = 32
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_en,
    input  logic [SAMPLE_W-1:0] i_sample,
    input  logic [ENV_W-1:0]    i_env,
    output logic [SAMPLE_W-1:0] o_sample,
    output logic                o_valid
);

    localparam int PROD_W = SAMPLE_W + ENV_W + 1;

    logic signed [PROD_W-1:0] w_sample_ext;
    logic signed [PROD_W-1:0] w_env_ext;
    logic signed [PROD_W-1:0] w_prod;
    logic                     w_prod_unused;
    logic [SAMPLE_W-1:0]      r_sample;
    logic                     r_valid;

    // Operands are extended to the full product width so the low PROD_W bits
    // of the multiply are exact; the envelope is zero-extended (always positive).
    assign w_sample_ext = {{(ENV_W + 1){i_sample[SAMPLE_W-1]}}, i_sample};
    assign w_env_ext    = {{(SAMPLE_W + 1){1'b0}}, i_env};
    assign w_prod       = w_sample_ext * w_env_ext;

    // Selecting bits [ENV_W +: SAMPLE_W] is the arithmetic shift plus truncation;
    // the discarded fraction and top sign bit are folded here.
    assign w_prod_unused = ^{w_prod[PROD_W-1], w_prod[ENV_W-1:0]};

    // Output register: load the scaled sample and raise valid on each strobe.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sample <= {SAMPLE_W{1'b0}};
            r_valid  <= 1'b0;
        end else begin
            r_valid <= i_en;
            if (i_en) begin
                r_sample <= w_prod[ENV_W +: SAMPLE_W];
            end
        end
    end

    assign o_sample = r_sample;
    assign o_valid  = r_valid;

endmodule

// File: rtl/adsr_envelope.sv
// -----------------------------------------------------------------------------
// adsr_envelope
// Per-voice ADSR envelope generator with VCA. On each step_in strobe the gate
// is sampled, the envelope level and state advance, and the incoming sample is
// scaled by the level held before that update.
// Ports:
//   clk_in, rst_in (async active-low)
//   step_in            : sample strobe (one-cycle pulse)
//   gate_in            : note gate
//   attack_incr        : per-step attack increment (0 = instant)
//   decay_decr         : per-step decay decrement (0 = instant)
//   sustain_level      : sustain target
//   release_decr       : per-step release decrement (0 = instant)
//   sample_in          : signed oscillator sample
//   sample_out         : signed scaled sample
//   sample_valid_out   : one-cycle pulse when sample_out updates
//   env_out            : envelope level
//   state_out          : state encoding
//   active_out         : high when state is not IDLE
// -----------------------------------------------------------------------------
module adsr_envelope
    import synth_pkg::*;
#(
    parameter int ENV_W    = ENV_W_DEFAULT,
    parameter int SAMPLE_W = 32
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                step_in,
    input  logic                gate_in,
    input  logic [ENV_W-1:0]    attack_incr,
    input  logic [ENV_W-1:0]    decay_decr,
    input  logic [ENV_W-1:0]    sustain_level,
    input  logic [ENV_W-1:0]    release_decr,
    input  logic [SAMPLE_W-1:0] sample_in,
    output logic [SAMPLE_W-1:0] sample_out,
    output logic                sample_valid_out,
    output logic [ENV_W-1:0]    env_out,
    output logic [2:0]          state_out,
    output logic                active_out
);

    localparam logic [ENV_W-1:0] LP_ENV_MAX  = {ENV_W{1'b1}};
    localparam logic [ENV_W-1:0] LP_ENV_ZERO = {ENV_W{1'b0}};

    env_state_t       r_state;
    env_state_t       w_state_nxt;
    logic [ENV_W-1:0] r_env;
    logic [ENV_W-1:0] w_env_nxt;
    logic             r_gate_q;
    logic             r_active;

    logic             w_rise;
    logic [ENV_W:0]   w_attack_sum;
    logic [ENV_W:0]   w_decay_diff;
    logic [ENV_W:0]   w_release_diff;
    logic [ENV_W-1:0] w_attack_env;
    logic             w_attack_done;
    logic [ENV_W-1:0] w_decay_env;
    logic             w_decay_done;
    logic [ENV_W-1:0] w_release_env;
    logic             w_release_done;

    // Per-phase level arithmetic at ENV_W+1 bits so carry/borrow is visible.
    always_comb begin
        w_rise         = gate_in & ~r_gate_q;
        w_attack_sum   = {1'b0, r_env} + {1'b0, attack_incr};
        w_decay_diff   = {1'b0, r_env} - {1'b0, decay_decr};
        w_release_diff = {1'b0, r_env} - {1'b0, release_decr};

        // Attack saturates at full scale; a zero increment jumps straight there.
        if ((attack_incr == LP_ENV_ZERO) || w_attack_sum[ENV_W]) begin
            w_attack_env = LP_ENV_MAX;
        end else begin
            w_attack_env = w_attack_sum[ENV_W-1:0];
        end
        w_attack_done = (w_attack_env == LP_ENV_MAX);

        // Decay clamps at the sustain level; a sustain level at or above the
        // current level also lands here, allowing an upward jump.
        if ((decay_decr == LP_ENV_ZERO) || w_decay_diff[ENV_W] ||
            (w_decay_diff[ENV_W-1:0] <= sustain_level)) begin
            w_decay_env  = sustain_level;
            w_decay_done = 1'b1;
        end else begin
            w_decay_env  = w_decay_diff[ENV_W-1:0];
            w_decay_done = 1'b0;
        end

        // Release clamps at zero (borrow means underflow).
        if ((release_decr == LP_ENV_ZERO) || w_release_diff[ENV_W] ||
            (w_release_diff[ENV_W-1:0] == LP_ENV_ZERO)) begin
            w_release_env  = LP_ENV_ZERO;
            w_release_done = 1'b1;
        end else begin
            w_release_env  = w_release_diff[ENV_W-1:0];
            w_release_done = 1'b0;
        end
    end

    // Next-state and next-level selection; gate events take priority over the
    // per-state progression and apply their phase's arithmetic in the same step.
    always_comb begin
        w_state_nxt = r_state;
        w_env_nxt   = r_env;
        if (w_rise) begin
            w_env_nxt   = w_attack_env;
            w_state_nxt = w_attack_done ? ST_DECAY : ST_ATTACK;
        end else if (!gate_in && ((r_state == ST_ATTACK) || (r_state == ST_DECAY) ||
                                  (r_state == ST_SUSTAIN))) begin
            w_env_nxt   = w_release_env;
            w_state_nxt = w_release_done ? ST_IDLE : ST_RELEASE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_env_nxt   = LP_ENV_ZERO;
                    w_state_nxt = ST_IDLE;
                end
                ST_ATTACK: begin
                    w_env_nxt   = w_attack_env;
                    w_state_nxt = w_attack_done ? ST_DECAY : ST_ATTACK;
                end
                ST_DECAY: begin
                    w_env_nxt   = w_decay_env;
                    w_state_nxt = w_decay_done ? ST_SUSTAIN : ST_DECAY;
                end
                ST_SUSTAIN: begin
                    w_env_nxt   = sustain_level;
                    w_state_nxt = ST_SUSTAIN;
                end
                ST_RELEASE: begin
                    w_env_nxt   = w_release_env;
                    w_state_nxt = w_release_done ? ST_IDLE : ST_RELEASE;
                end
                default: begin
                    w_env_nxt   = LP_ENV_ZERO;
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // Envelope state registers: advance only on a sample strobe.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state  <= ST_IDLE;
            r_env    <= LP_ENV_ZERO;
            r_gate_q <= 1'b0;
            r_active <= 1'b0;
        end else if (step_in) begin
            r_state  <= w_state_nxt;
            r_env    <= w_env_nxt;
            r_gate_q <= gate_in;
            r_active <= (w_state_nxt != ST_IDLE);
        end
    end

    // The VCA sees the level from before this step's update.
    env_vca_mult #(
        .ENV_W    (ENV_W),
        .SAMPLE_W (SAMPLE_W)
    ) u_vca (
        .i_clk    (clk_in),
        .i_rst_n  (rst_in),
        .i_en     (step_in),
        .i_sample (sample_in),
        .i_env    (r_env),
        .o_sample (sample_out),
        .o_valid  (sample_valid_out)
    );

    assign env_out    = r_env;
    assign state_out  = r_state;
    assign active_out = r_active;

endmodule

// File: tb/tb_adsr_envelope.sv
// -----------------------------------------------------------------------------
// tb_adsr_envelope
// Directed scoreboard bench: each strobe pushes its hand-computed expected
// level/state/sample; a monitor pops and compares on every sample_valid_out.
// -----------------------------------------------------------------------------
module tb_adsr_envelope;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        step_in;
    logic        gate_in;
    logic [15:0] attack_incr;
    logic [15:0] decay_decr;
    logic [15:0] sustain_level;
    logic [15:0] release_decr;
    logic [31:0] sample_in;
    logic [31:0] sample_out;
    logic        sample_valid_out;
    logic [15:0] env_out;
    logic [2:0]  state_out;
    logic        active_out;

    typedef struct {
        logic [15:0] env;
        logic [2:0]  st;
        int          smp;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    adsr_envelope #(.ENV_W(16), .SAMPLE_W(32)) dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .step_in          (step_in),
        .gate_in          (gate_in),
        .attack_incr      (attack_incr),
        .decay_decr       (decay_decr),
        .sustain_level    (sustain_level),
        .release_decr     (release_decr),
        .sample_in        (sample_in),
        .sample_out       (sample_out),
        .sample_valid_out (sample_valid_out),
        .env_out          (env_out),
        .state_out        (state_out),
        .active_out       (active_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string nm, input logic signed [63:0] act,
                       input logic signed [63:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp_v);
        end
    endtask

    // Monitor: compare each DUT update against the oldest expected entry.
    always @(negedge clk_in) begin
        if (rst_in === 1'b1 && sample_valid_out === 1'b1) begin
            if (q.size() == 0) begin
                chk("unexpected_valid", 64'sd1, 64'sd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("env_out",    {48'd0, env_out}, {48'd0, e.env});
                chk("state_out",  {61'd0, state_out}, {61'd0, e.st});
                chk("active_out", {63'd0, active_out}, {63'd0, (e.st != 3'd0)});
                chk("sample_out", $signed(sample_out), e.smp);
            end
        end
    end

    // One strobe: drive inputs at a negedge, record the expectation, hold one cycle.
    task automatic do_step(input logic g, input int smp, input logic [15:0] e_env,
                           input logic [2:0] e_st, input int e_smp);
        exp_t e;
        gate_in   = g;
        sample_in = smp;
        step_in   = 1'b1;
        e.env = e_env;
        e.st  = e_st;
        e.smp = e_smp;
        q.push_back(e);
        @(negedge clk_in);
    endtask

    task automatic gap(input int n);
        step_in = 1'b0;
        repeat (n) @(negedge clk_in);
    endtask

    task automatic drain();
        for (int i = 0; i < 20; i++) begin
            if (q.size() == 0) break;
            @(negedge clk_in);
        end
        chk("queue_drained", q.size(), 64'sd0);
    endtask

    initial begin
        rst_in        = 1'b0;
        step_in       = 1'b0;
        gate_in       = 1'b0;
        attack_incr   = 16'h4000;
        decay_decr    = 16'h1000;
        sustain_level = 16'h8000;
        release_decr  = 16'h2000;
        sample_in     = 32'd0;

        #12;
        chk("rst_sample_out", sample_out, 64'sd0);
        chk("rst_valid",      sample_valid_out, 64'sd0);
        chk("rst_env",        env_out, 64'sd0);
        chk("rst_state",      state_out, 64'sd0);
        chk("rst_active",     active_out, 64'sd0);
        @(negedge clk_in);
        rst_in = 1'b1;
        gap(2);

        // Attack ramp (first strobe isolated, the rest back-to-back).
        do_step(1'b1, 100, 16'h4000, 3'd1, 0);
        gap(1);
        do_step(1'b1, 100, 16'h8000, 3'd1, 25);
        do_step(1'b1, 100, 16'hC000, 3'd1, 50);
        do_step(1'b1, 100, 16'hFFFF, 3'd2, 75);
        gap(2);

        // Decay to sustain, with VCA at full scale.
        do_step(1'b1, 127,  16'hEFFF, 3'd2, 126);
        do_step(1'b1, -128, 16'hDFFF, 3'd2, -120);
        do_step(1'b1, 0,    16'hCFFF, 3'd2, 0);
        do_step(1'b1, 0,    16'hBFFF, 3'd2, 0);
        do_step(1'b1, 0,    16'hAFFF, 3'd2, 0);
        do_step(1'b1, 0,    16'h9FFF, 3'd2, 0);
        do_step(1'b1, 0,    16'h8FFF, 3'd2, 0);
        do_step(1'b1, 0,    16'h8000, 3'd3, 0);
        gap(1);
        do_step(1'b1, -101, 16'h8000, 3'd3, -51);
        sustain_level = 16'h6000;
        gap(1);
        do_step(1'b1, 0, 16'h6000, 3'd3, 0);

        // Release to idle.
        do_step(1'b0, 0, 16'h4000, 3'd4, 0);
        do_step(1'b0, 0, 16'h2000, 3'd4, 0);
        do_step(1'b0, 0, 16'h0000, 3'd0, 0);

        // Retrigger from release continues from the current level.
        do_step(1'b1, 0, 16'h4000, 3'd1, 0);
        do_step(1'b1, 0, 16'h8000, 3'd1, 0);
        do_step(1'b0, 0, 16'h6000, 3'd4, 0);
        do_step(1'b0, 0, 16'h4000, 3'd4, 0);
        do_step(1'b1, 0, 16'h8000, 3'd1, 0);

        // Zero rates: every phase completes in a single step.
        gap(1);
        attack_incr   = 16'h0000;
        decay_decr    = 16'h0000;
        release_decr  = 16'h0000;
        sustain_level = 16'h5000;
        gap(1);
        do_step(1'b0, 0,    16'h0000, 3'd0, 0);
        do_step(1'b1, 0,    16'hFFFF, 3'd2, 0);
        do_step(1'b1, -128, 16'h5000, 3'd3, -128);
        do_step(1'b1, 127,  16'h5000, 3'd3, 39);
        do_step(1'b0, 0,    16'h0000, 3'd0, 0);

        // Reset asserted mid-attack clears outputs without a clock edge.
        attack_incr = 16'h4000;
        do_step(1'b1, 0,   16'h4000, 3'd1, 0);
        do_step(1'b1, 100, 16'h8000, 3'd1, 25);
        gap(1);
        drain();
        #2;
        rst_in = 1'b0;
        #1;
        chk("mid_rst_sample_out", sample_out, 64'sd0);
        chk("mid_rst_valid",      sample_valid_out, 64'sd0);
        chk("mid_rst_env",        env_out, 64'sd0);
        chk("mid_rst_state",      state_out, 64'sd0);
        chk("mid_rst_active",     active_out, 64'sd0);
        @(negedge clk_in);
        rst_in = 1'b1;
        gap(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
